// File: rtl/aq_memcpy_ctrl.sv
// Sequencer for one memory-to-memory copy staged through aq_fifo.
// Concurrent read- and write-burst FSMs; a space reservation keeps the FIFO from overflowing.
module aq_memcpy_ctrl #(
    parameter int FIFO_DEPTH = 10,
    parameter int FIFO_WIDTH = 64,
    parameter int ADRS_WIDTH = 32,
    parameter int MAX_BURST  = 16
) (
    input  logic                  CLK,
    input  logic                  RST_N,
    input  logic                  START,
    input  logic [ADRS_WIDTH-1:0] SRC_ADRS,
    input  logic [ADRS_WIDTH-1:0] DST_ADRS,
    input  logic [31:0]           LENGTH,
    output logic                  BUSY,
    output logic                  DONE,
    output logic                  RD_REQ,
    output logic [ADRS_WIDTH-1:0] RD_ADRS,
    output logic [8:0]            RD_LEN,
    input  logic                  RD_ACK,
    input  logic                  RD_DVALID,
    output logic                  FIFO_WR_LAST,
    output logic                  WR_REQ,
    output logic [ADRS_WIDTH-1:0] WR_ADRS,
    output logic [8:0]            WR_LEN,
    input  logic                  WR_ACK,
    output logic                  WR_DVALID,
    input  logic                  WR_DREADY,
    output logic                  FIFO_RD_ENA,
    input  logic                  FIFO_RD_EMPTY
);
    localparam int          BB_SHIFT     = $clog2(FIFO_WIDTH / 8);
    localparam int          RESV_W       = FIFO_DEPTH + 1;
    localparam logic [31:0] FIFO_ENTRIES = 32'(1) << FIFO_DEPTH;
    localparam logic [31:0] MAXB         = 32'(MAX_BURST);

    typedef enum logic       {T_IDLE, T_RUN}         top_t;
    typedef enum logic [1:0] {R_IDLE, R_REQ, R_DATA} rd_t;
    typedef enum logic [1:0] {W_IDLE, W_REQ, W_DATA} wr_t;

    top_t              top_st;
    rd_t               rd_st;
    wr_t               wr_st;
    logic [31:0]       rd_rem, wr_rem;
    logic [RESV_W-1:0] resv, wavail;
    logic [8:0]        rd_cnt, wr_cnt;
    logic [8:0]        rd_nlen, wr_nlen;
    logic              rd_fire, wr_fire, rd_beat, wr_last_beat, resv_ok, start_ok;

    function automatic logic [8:0] burst_len(input logic [31:0] rem);
        return (rem >= MAXB) ? MAXB[8:0] : rem[8:0];
    endfunction

    function automatic logic [ADRS_WIDTH-1:0] adrs_step(input logic [8:0] len);
        return ADRS_WIDTH'(len) << BB_SHIFT;
    endfunction

    assign rd_nlen      = burst_len(rd_rem);
    assign wr_nlen      = burst_len(wr_rem);
    assign rd_fire      = RD_REQ & RD_ACK;
    assign wr_fire      = WR_REQ & WR_ACK;
    assign rd_beat      = (rd_st == R_DATA) & RD_DVALID;
    assign FIFO_WR_LAST = rd_beat & (rd_cnt == 9'd1);
    assign WR_DVALID    = (wr_st == W_DATA) & ~FIFO_RD_EMPTY;
    assign FIFO_RD_ENA  = WR_DVALID & WR_DREADY;
    assign wr_last_beat = FIFO_RD_ENA & (wr_cnt == 9'd1);
    assign resv_ok      = (32'(resv) + 32'(rd_nlen)) <= FIFO_ENTRIES;
    assign start_ok     = (top_st == T_IDLE) & START;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            top_st <= T_IDLE;
            BUSY   <= 1'b0;
            DONE   <= 1'b0;
        end else begin
            DONE <= 1'b0;
            case (top_st)
                T_IDLE: if (START) begin
                    if (LENGTH == 32'd0) begin
                        DONE <= 1'b1;
                    end else begin
                        top_st <= T_RUN;
                        BUSY   <= 1'b1;
                    end
                end
                T_RUN: if (wr_last_beat && wr_rem == 32'd0) begin
                    top_st <= T_IDLE;
                    BUSY   <= 1'b0;
                    DONE   <= 1'b1;
                end
                default: top_st <= T_IDLE;
            endcase
        end
    end

    // resv: beats requested from the source and not yet popped; wavail: beats landed but unclaimed
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            resv   <= '0;
            wavail <= '0;
        end else begin
            resv   <= resv + (rd_fire ? RESV_W'(RD_LEN) : '0) - (FIFO_RD_ENA ? RESV_W'(1) : '0);
            wavail <= wavail + (rd_beat ? RESV_W'(1) : '0) - (wr_fire ? RESV_W'(WR_LEN) : '0);
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            rd_st   <= R_IDLE;
            rd_rem  <= '0;
            rd_cnt  <= '0;
            RD_REQ  <= 1'b0;
            RD_ADRS <= '0;
            RD_LEN  <= '0;
        end else begin
            case (rd_st)
                R_IDLE: begin
                    if (start_ok) begin
                        rd_rem  <= LENGTH;
                        RD_ADRS <= SRC_ADRS;
                    end else if (top_st == T_RUN && rd_rem != 32'd0 && resv_ok) begin
                        RD_LEN <= rd_nlen;
                        RD_REQ <= 1'b1;
                        rd_st  <= R_REQ;
                    end
                end
                R_REQ: if (RD_ACK) begin
                    RD_REQ  <= 1'b0;
                    rd_rem  <= rd_rem - 32'(RD_LEN);
                    RD_ADRS <= RD_ADRS + adrs_step(RD_LEN);
                    rd_cnt  <= RD_LEN;
                    rd_st   <= R_DATA;
                end
                R_DATA: if (RD_DVALID) begin
                    rd_cnt <= rd_cnt - 9'd1;
                    if (rd_cnt == 9'd1) rd_st <= R_IDLE;
                end
                default: rd_st <= R_IDLE;
            endcase
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            wr_st   <= W_IDLE;
            wr_rem  <= '0;
            wr_cnt  <= '0;
            WR_REQ  <= 1'b0;
            WR_ADRS <= '0;
            WR_LEN  <= '0;
        end else begin
            case (wr_st)
                W_IDLE: begin
                    if (start_ok) begin
                        wr_rem  <= LENGTH;
                        WR_ADRS <= DST_ADRS;
                    end else if (top_st == T_RUN && wr_rem != 32'd0 &&
                                 32'(wavail) >= 32'(wr_nlen)) begin
                        WR_LEN <= wr_nlen;
                        WR_REQ <= 1'b1;
                        wr_st  <= W_REQ;
                    end
                end
                W_REQ: if (WR_ACK) begin
                    WR_REQ  <= 1'b0;
                    wr_rem  <= wr_rem - 32'(WR_LEN);
                    WR_ADRS <= WR_ADRS + adrs_step(WR_LEN);
                    wr_cnt  <= WR_LEN;
                    wr_st   <= W_DATA;
                end
                // an empty FIFO simply withholds WR_DVALID, so a stall never drops a beat
                W_DATA: if (FIFO_RD_ENA) begin
                    wr_cnt <= wr_cnt - 9'd1;
                    if (wr_cnt == 9'd1) wr_st <= W_IDLE;
                end
                default: wr_st <= W_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_aq_memcpy_ctrl.sv
// Directed bench for aq_memcpy_ctrl with a small source/FIFO/destination model (FIFO_DEPTH=4).
module tb_aq_memcpy_ctrl;
    logic        CLK, RST_N, START;
    logic [31:0] SRC_ADRS, DST_ADRS, LENGTH;
    logic        BUSY, DONE, RD_REQ, RD_ACK, RD_DVALID, FIFO_WR_LAST;
    logic [31:0] RD_ADRS, WR_ADRS;
    logic [8:0]  RD_LEN, WR_LEN;
    logic        WR_REQ, WR_ACK, WR_DVALID, WR_DREADY, FIFO_RD_ENA, FIFO_RD_EMPTY;

    aq_memcpy_ctrl #(.FIFO_DEPTH(4), .FIFO_WIDTH(64), .ADRS_WIDTH(32), .MAX_BURST(16)) dut (
        .CLK(CLK), .RST_N(RST_N), .START(START), .SRC_ADRS(SRC_ADRS), .DST_ADRS(DST_ADRS),
        .LENGTH(LENGTH), .BUSY(BUSY), .DONE(DONE), .RD_REQ(RD_REQ), .RD_ADRS(RD_ADRS),
        .RD_LEN(RD_LEN), .RD_ACK(RD_ACK), .RD_DVALID(RD_DVALID), .FIFO_WR_LAST(FIFO_WR_LAST),
        .WR_REQ(WR_REQ), .WR_ADRS(WR_ADRS), .WR_LEN(WR_LEN), .WR_ACK(WR_ACK),
        .WR_DVALID(WR_DVALID), .WR_DREADY(WR_DREADY), .FIFO_RD_ENA(FIFO_RD_ENA),
        .FIFO_RD_EMPTY(FIFO_RD_EMPTY)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int total = 0, bad = 0;
    logic        rnd = 1'b0, dready_en = 1'b1;
    logic [31:0] fq[$];
    logic [31:0] rd_a[8], wr_a[8];
    logic [8:0]  rd_l[8], wr_l[8];
    int          rd_n, wr_n, rd_pend, pops, pops_at_done, done_cnt, lasts;
    logic        busy_seen, rdreq_seen, wrreq_seen;
    logic [31:0] rd_tok, exp_tok;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Source memory returns its own address as data; FIFO model shows a 1-cycle empty lag.
    always @(negedge CLK) begin
        if (!RST_N) begin
            RD_ACK = 0; RD_DVALID = 0; WR_ACK = 0; WR_DREADY = 0; FIFO_RD_EMPTY = 1;
            fq.delete(); rd_pend = 0;
        end else begin
            RD_ACK        = RD_REQ && (!rnd || $urandom_range(0, 2) != 0);
            RD_DVALID     = (rd_pend > 0) && (!rnd || $urandom_range(0, 3) != 0);
            WR_ACK        = WR_REQ && (!rnd || $urandom_range(0, 2) != 0);
            WR_DREADY     = dready_en && (!rnd || $urandom_range(0, 2) != 0);
            FIFO_RD_EMPTY = (fq.size() == 0);
            #1;
            if (START && !BUSY) begin
                rd_n = 0; wr_n = 0; pops = 0; pops_at_done = 0; done_cnt = 0; lasts = 0;
                busy_seen = 0; rdreq_seen = 0; wrreq_seen = 0; exp_tok = SRC_ADRS;
            end
            if (RD_DVALID) begin
                chk("wr_last", FIFO_WR_LAST, rd_pend == 1);
                if (FIFO_WR_LAST) lasts++;
                fq.push_back(rd_tok);
                rd_tok += 8;
                rd_pend--;
                chk("fifo_bound", fq.size() <= 16, 1);
            end
            if (RD_REQ && RD_ACK) begin
                if (rd_n < 8) begin rd_a[rd_n] = RD_ADRS; rd_l[rd_n] = RD_LEN; end
                rd_n++;
                rd_pend = int'(RD_LEN);
                rd_tok  = RD_ADRS;
            end
            if (FIFO_RD_ENA) begin
                chk("pop_nonempty", fq.size() != 0, 1);
                if (fq.size() != 0) chk("data_order", fq.pop_front(), exp_tok);
                exp_tok += 8;
                pops++;
            end
            if (WR_REQ && WR_ACK) begin
                if (wr_n < 8) begin wr_a[wr_n] = WR_ADRS; wr_l[wr_n] = WR_LEN; end
                wr_n++;
            end
            if (DONE) begin done_cnt++; pops_at_done = pops; end
            if (BUSY) busy_seen = 1;
            if (RD_REQ) rdreq_seen = 1;
            if (WR_REQ) wrreq_seen = 1;
        end
    end

    task automatic do_start(input logic [31:0] s, input logic [31:0] d, input logic [31:0] l);
        @(negedge CLK);
        SRC_ADRS = s; DST_ADRS = d; LENGTH = l; START = 1;
        @(negedge CLK);
        START = 0;
    endtask

    task automatic wait_done(input int budget, input string tag);
        int d0 = done_cnt;
        for (int i = 0; i < budget && done_cnt == d0; i++) begin
            @(negedge CLK); #3;
        end
        chk(tag, done_cnt - d0, 1);
    endtask

    initial begin
        START = 0; SRC_ADRS = 0; DST_ADRS = 0; LENGTH = 0; RST_N = 1;
        #2 RST_N = 0;
        repeat (3) @(negedge CLK);
        #3;
        chk("rst_ctl", {BUSY, DONE, RD_REQ, WR_REQ, WR_DVALID, FIFO_RD_ENA, FIFO_WR_LAST}, 0);
        chk("rst_adrs", {RD_ADRS, WR_ADRS}, 0);
        chk("rst_len", {RD_LEN, WR_LEN}, 0);
        @(negedge CLK); RST_N = 1;

        // 40 beats, zero-wait: bursts 16,16,8; a START mid-run must be ignored
        do_start(32'h1000, 32'h8000, 40);
        repeat (10) @(negedge CLK);
        #3 chk("b40_busy", BUSY, 1);
        do_start(32'h5555_0000, 32'h6666_0000, 7);
        wait_done(600, "b40_done");
        chk("b40_rd_n", rd_n, 3);
        chk("b40_rd0", {rd_a[0], 7'd0, rd_l[0]}, {32'h1000, 16'd16});
        chk("b40_rd1", {rd_a[1], 7'd0, rd_l[1]}, {32'h1080, 16'd16});
        chk("b40_rd2", {rd_a[2], 7'd0, rd_l[2]}, {32'h1100, 16'd8});
        chk("b40_wr_n", wr_n, 3);
        chk("b40_wr0", {wr_a[0], 7'd0, wr_l[0]}, {32'h8000, 16'd16});
        chk("b40_wr1", {wr_a[1], 7'd0, wr_l[1]}, {32'h8080, 16'd16});
        chk("b40_wr2", {wr_a[2], 7'd0, wr_l[2]}, {32'h8100, 16'd8});
        chk("b40_pops_at_done", pops_at_done, 40);
        @(negedge CLK); #3;
        chk("b40_idle", {BUSY, DONE}, 0);

        // reserve limit: 16-entry FIFO, destination stalled
        dready_en = 0;
        do_start(32'h2000, 32'h9000, 64);
        repeat (80) @(negedge CLK);
        #3;
        chk("resv_rd_n", rd_n, 1);
        chk("resv_rdreq", RD_REQ, 0);
        chk("resv_cnt", dut.resv, 16);
        chk("resv_pops", pops, 0);
        dready_en = 1;
        wait_done(1500, "resv_done");
        chk("resv_rd_n_end", rd_n, 4);
        chk("resv_pops_end", pops, 64);

        // zero length
        do_start(32'h3000, 32'hA000, 0);
        #3 chk("len0_done", DONE, 1);
        @(negedge CLK); #3 chk("len0_done_pulse", DONE, 0);
        repeat (5) @(negedge CLK);
        #3;
        chk("len0_quiet", {busy_seen, rdreq_seen, wrreq_seen}, 0);
        chk("len0_done_cnt", done_cnt, 1);

        // random stalls on both sides
        rnd = 1;
        do_start(32'h4000, 32'hB000, 100);
        wait_done(5000, "rnd_done");
        chk("rnd_pops", pops, 100);
        repeat (20) @(negedge CLK);
        #3;
        chk("rnd_one_done", done_cnt, 1);
        chk("rnd_idle", BUSY, 0);
        rnd = 0;

        // reset during the second read burst, then a short copy
        do_start(32'h2000, 32'h6000, 40);
        for (int i = 0; i < 300 && !(rd_n == 2 && rd_pend > 0); i++) begin
            @(negedge CLK); #3;
        end
        chk("mid_reached_b2", rd_n, 2);
        RST_N = 0;
        #1;
        chk("mid_rst_ctl", {BUSY, DONE, RD_REQ, WR_REQ, WR_DVALID, FIFO_RD_ENA, FIFO_WR_LAST}, 0);
        chk("mid_rst_adrs", {RD_ADRS, WR_ADRS}, 0);
        chk("mid_rst_len", {RD_LEN, WR_LEN}, 0);
        repeat (2) @(negedge CLK);
        RST_N = 1;
        do_start(32'h3000, 32'h7000, 5);
        wait_done(200, "mid_len5_done");
        chk("mid_len5_rd", {rd_n[7:0], rd_a[0], 7'd0, rd_l[0]}, {8'd1, 32'h3000, 16'd5});
        chk("mid_len5_wr", {wr_n[7:0], wr_a[0], 7'd0, wr_l[0]}, {8'd1, 32'h7000, 16'd5});
        chk("mid_len5_pops", pops, 5);

        // address wrap at the top of the space
        do_start(32'hFFFF_FFC0, 32'hC000, 16);
        wait_done(200, "wrap_done");
        chk("wrap_rd0", {rd_a[0], 7'd0, rd_l[0]}, {32'hFFFF_FFC0, 16'd16});
        chk("wrap_rd_adrs", RD_ADRS, 32'h0000_0040);
        chk("wrap_wr_adrs", WR_ADRS, 32'h0000_C080);
        chk("wrap_lasts", lasts, 1);
        chk("wrap_pops", pops, 16);

        repeat (3) @(negedge CLK);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
